// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and types for the real-time clock controller.
//   - rtc_state_e : FSM state encoding (RUN, SET_HR, SET_MIN, SET_SEC).
//   - *_MAX_T     : highest legal tens digit for each field.
//   - HR_MAX_U_AT_MAX_T : highest hours units digit when hours tens is at its maximum.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } rtc_state_e;

  localparam logic [3:0] SEC_MAX_T         = 4'd5;
  localparam logic [3:0] MIN_MAX_T         = 4'd5;
  localparam logic [3:0] HR_MAX_T          = 4'd2;
  localparam logic [3:0] HR_MAX_U_AT_MAX_T = 4'd3;
  localparam logic [3:0] BCD_MAX           = 4'd9;

endpackage

// File: rtl/rtc_bcd_pair.sv
// rtc_bcd_pair: two-digit BCD counter (tens:units) with wrap and carry-out.
// Ports:
//   clk, rset      : clock, synchronous active-low reset.
//   inc_en_i       : increment request from the owner (button / tick).
//   carry_i        : carry arriving from the lower field.
//   tens_o,units_o : registered BCD digits.
//   carry_o        : combinational; high when the pair wraps on this step.
// Units count 0..9, except when tens is at T_MAX, where units stop at U_MAX_AT_T_MAX.
module rtc_bcd_pair
  import rtc_pkg::*;
#(
  parameter logic [3:0] T_MAX          = 4'd5,
  parameter logic [3:0] U_MAX_AT_T_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rset,
  input  logic       inc_en_i,
  input  logic       carry_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       carry_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       step_s;
  logic       at_max_s;
  logic       illegal_s;

  assign step_s    = inc_en_i | carry_i;
  assign at_max_s  = (tens_q == T_MAX) && (units_q == U_MAX_AT_T_MAX);
  // Any value outside the legal range is forced back to 00.
  assign illegal_s = (tens_q > T_MAX) || (units_q > BCD_MAX) ||
                     ((tens_q == T_MAX) && (units_q > U_MAX_AT_T_MAX));

  // Next-value and carry computation for the pair.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    carry_o = 1'b0;
    if (illegal_s) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (step_s) begin
      if (at_max_s) begin
        tens_d  = 4'd0;
        units_d = 4'd0;
        carry_o = 1'b1;
      end else if (units_q == BCD_MAX) begin
        tens_d  = tens_q + 4'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end else begin
      tens_d  = tens_q;
      units_d = units_q;
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (!rset) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/rtc_time_controller.sv
// rtc_time_controller: 1 Hz prescaler, HH:MM:SS BCD chain and set-time FSM.
// Ports:
//   clk, rset             : clock, synchronous active-low reset.
//   set_mode              : level, request time-setting mode.
//   btn_next, btn_inc     : one-cycle pulses; select next field / increment field.
//   h10,h1,m10,m1,s10,s1  : registered BCD digits.
//   sec_tick              : registered one-cycle pulse per second (RUN only).
//   state                 : FSM state (0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC).
module rtc_time_controller
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W   = 26
) (
  input  logic       clk,
  input  logic       rset,
  input  logic       set_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [3:0] h10,
  output logic [3:0] h1,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic [3:0] s10,
  output logic [3:0] s1,
  output logic       sec_tick,
  output logic [1:0] state
);

  localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

  rtc_state_e        state_q;
  logic [TICK_W-1:0] cnt_q;
  logic              tick_q;

  logic run_s;
  logic tick_adv_s;
  logic hr_inc_s, min_inc_s, sec_inc_s;
  logic sec_carry_s, min_carry_s, hr_carry_s;

  assign run_s      = (state_q == ST_RUN);
  assign tick_adv_s = run_s && (cnt_q == CNT_LAST);

  // Field increments only while set_mode is still held; dropping it wins.
  assign hr_inc_s  = set_mode && btn_inc && (state_q == ST_SET_HR);
  assign min_inc_s = set_mode && btn_inc && (state_q == ST_SET_MIN);
  assign sec_inc_s = set_mode && btn_inc && (state_q == ST_SET_SEC);

  // FSM, prescaler and tick pulse.
  always_ff @(posedge clk) begin
    if (!rset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          state_q <= set_mode ? ST_SET_HR : ST_RUN;
        end
        ST_SET_HR: begin
          if (!set_mode)     state_q <= ST_RUN;
          else if (btn_next) state_q <= ST_SET_MIN;
          else               state_q <= ST_SET_HR;
        end
        ST_SET_MIN: begin
          if (!set_mode)     state_q <= ST_RUN;
          else if (btn_next) state_q <= ST_SET_SEC;
          else               state_q <= ST_SET_MIN;
        end
        ST_SET_SEC: begin
          if (!set_mode)     state_q <= ST_RUN;
          else if (btn_next) state_q <= ST_SET_HR;
          else               state_q <= ST_SET_SEC;
        end
        default: state_q <= ST_RUN;
      endcase

      // Prescaler only runs in RUN; held at 0 otherwise so a full second
      // elapses after leaving set mode.
      if (!run_s) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + TICK_W'(1);
        tick_q <= 1'b0;
      end
    end
  end

  // Seconds advance on the tick or on a set-mode increment.
  rtc_bcd_pair #(.T_MAX(SEC_MAX_T), .U_MAX_AT_T_MAX(BCD_MAX)) u_sec (
    .clk      (clk),
    .rset     (rset),
    .inc_en_i (tick_adv_s | sec_inc_s),
    .carry_i  (1'b0),
    .tens_o   (s10),
    .units_o  (s1),
    .carry_o  (sec_carry_s)
  );

  // Carries are gated to RUN so a set-mode wrap never spills into another field.
  rtc_bcd_pair #(.T_MAX(MIN_MAX_T), .U_MAX_AT_T_MAX(BCD_MAX)) u_min (
    .clk      (clk),
    .rset     (rset),
    .inc_en_i (min_inc_s),
    .carry_i  (run_s & sec_carry_s),
    .tens_o   (m10),
    .units_o  (m1),
    .carry_o  (min_carry_s)
  );

  rtc_bcd_pair #(.T_MAX(HR_MAX_T), .U_MAX_AT_T_MAX(HR_MAX_U_AT_MAX_T)) u_hr (
    .clk      (clk),
    .rset     (rset),
    .inc_en_i (hr_inc_s),
    .carry_i  (run_s & min_carry_s),
    .tens_o   (h10),
    .units_o  (h1),
    .carry_o  (hr_carry_s)
  );

  assign sec_tick = tick_q;
  assign state    = state_q;

  // The day wrap out of the hours pair has no consumer.
  logic unused_s;
  assign unused_s = hr_carry_s;

endmodule

// File: tb/tb_rtc_time_controller.sv
// Directed testbench for rtc_time_controller with TICK_DIV=4.
module tb_rtc_time_controller;

  logic       clk = 1'b0;
  logic       rset, set_mode, btn_next, btn_inc;
  logic [3:0] h10, h1, m10, m1, s10, s1;
  logic       sec_tick;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  rtc_time_controller #(.TICK_DIV(4), .TICK_W(26)) dut (
    .clk      (clk),
    .rset     (rset),
    .set_mode (set_mode),
    .btn_next (btn_next),
    .btn_inc  (btn_inc),
    .h10      (h10),
    .h1       (h1),
    .m10      (m10),
    .m1       (m1),
    .s10      (s10),
    .s1       (s1),
    .sec_tick (sec_tick),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check_eq({tag, ".h10"}, 32'(h10), 32'(h / 10));
    check_eq({tag, ".h1"},  32'(h1),  32'(h % 10));
    check_eq({tag, ".m10"}, 32'(m10), 32'(m / 10));
    check_eq({tag, ".m1"},  32'(m1),  32'(m % 10));
    check_eq({tag, ".s10"}, 32'(s10), 32'(s / 10));
    check_eq({tag, ".s1"},  32'(s1),  32'(s % 10));
  endtask

  task automatic do_reset();
    set_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_next = 1'b0;
    rset     = 1'b0;
    cyc();
    rset = 1'b1;
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      btn_inc = 1'b1;
      cyc();
    end
    btn_inc = 1'b0;
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    cyc();
    btn_next = 1'b0;
  endtask

  // From RUN right after reset: enter set mode and dial in h:m:s; ends in SET_SEC.
  task automatic set_time(input int h, input int m, input int s);
    set_mode = 1'b1;
    cyc();
    press_inc(h);
    press_next();
    press_inc(m);
    press_next();
    press_inc(s);
  endtask

  // Leave set mode: one edge to reach RUN, then expect the tick on the 4th edge.
  task automatic exit_and_tick(input string tag);
    int n;
    set_mode = 1'b0;
    cyc();
    check_eq({tag, ".state_run"}, 32'(state), 32'd0);
    check_eq({tag, ".no_tick_at_exit"}, 32'(sec_tick), 32'd0);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (sec_tick) begin
        n = i;
        break;
      end
    end
    check_eq({tag, ".tick_latency"}, 32'(n), 32'd4);
  endtask

  initial begin
    int n;
    bit seen;
    rset = 1'b0; set_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;

    // Reset and tick timing.
    cyc();
    cyc();
    check_time("reset", 0, 0, 0);
    check_eq("reset.state", 32'(state), 32'd0);
    check_eq("reset.tick", 32'(sec_tick), 32'd0);
    rset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check_eq($sformatf("tick.k%0d", k), 32'(sec_tick), 32'((k % 4) == 0));
      if ((k % 4) == 0) check_eq($sformatf("tick.s1_k%0d", k), 32'(s1), 32'(k / 4));
    end

    // Buttons in RUN are ignored.
    do_reset();
    btn_inc = 1'b1; btn_next = 1'b1;
    cyc();
    btn_inc = 1'b0; btn_next = 1'b0;
    check_eq("run_btn.state", 32'(state), 32'd0);
    check_time("run_btn", 0, 0, 0);

    // Day rollover.
    do_reset();
    set_time(23, 59, 59);
    check_time("set23", 23, 59, 59);
    check_eq("set23.state", 32'(state), 32'd3);
    exit_and_tick("day");
    check_time("day", 0, 0, 0);

    // Ten-hour carries.
    do_reset();
    set_time(9, 59, 59);
    exit_and_tick("h09");
    check_time("h09", 10, 0, 0);
    do_reset();
    set_time(19, 59, 59);
    exit_and_tick("h19");
    check_time("h19", 20, 0, 0);

    // Hours field wrap with no tick during set.
    do_reset();
    set_mode = 1'b1;
    cyc();
    seen = 1'b0;
    repeat (25) begin
      btn_inc = 1'b1;
      cyc();
      if (sec_tick) seen = 1'b1;
    end
    btn_inc = 1'b0;
    check_time("hwrap", 1, 0, 0);
    check_eq("hwrap.state", 32'(state), 32'd1);
    check_eq("hwrap.no_tick", 32'(seen), 32'd0);

    // Simultaneous inc + next in SET_MIN at 59.
    do_reset();
    set_mode = 1'b1;
    cyc();
    press_next();
    press_inc(59);
    check_time("min59", 0, 59, 0);
    btn_inc = 1'b1; btn_next = 1'b1;
    cyc();
    btn_inc = 1'b0; btn_next = 1'b0;
    check_time("simul", 0, 0, 0);
    check_eq("simul.state", 32'(state), 32'd3);

    // set_mode drop with buttons: buttons ignored, back to RUN.
    btn_inc = 1'b1; btn_next = 1'b1; set_mode = 1'b0;
    cyc();
    btn_inc = 1'b0; btn_next = 1'b0;
    check_eq("drop.state", 32'(state), 32'd0);
    check_time("drop", 0, 0, 0);

    // Reset in the middle of SET_SEC.
    do_reset();
    set_time(12, 34, 56);
    check_time("set12", 12, 34, 56);
    check_eq("set12.state", 32'(state), 32'd3);
    set_mode = 1'b0;
    rset = 1'b0;
    cyc();
    rset = 1'b1;
    check_eq("midrst.state", 32'(state), 32'd0);
    check_time("midrst", 0, 0, 0);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (sec_tick) begin
        n = i;
        break;
      end
    end
    check_eq("midrst.tick_latency", 32'(n), 32'd4);
    check_time("midrst_tick", 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
